pipe_stage_buf: RTL

//  Parametrised elastic pipeline register between two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 69 ++++++
 rtl/pipe_ptr_ctr.sv | 37 +++
 rtl/pipe_stage_buf.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package  : pipe_pkg                                                   |
// | Purpose  : Shared stage payload structs and default buffer depth for  |
// |            the elastic pipeline registers between core stages.        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package pipe_pkg;

  // Default number of entries in each inter-stage buffer.
  localparam int PIPE_DEPTH = 2;

  // ALU operation selector carried from decode to execute.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Stage payloads carry no valid bit: validity lives in the handshake,
  // so the same buffer works for every stage boundary.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        use_imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_wr;
  } mem_wb_t;

  // Pointer width for a buffer of the given depth; a single-entry buffer
  // still gets a one-bit pointer so the port never collapses to zero width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_ptr_ctr.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pipe_ptr_ctr                                               |
// | Purpose  : Wrapping FIFO pointer with increment enable and            |
// |            synchronous clear.                                         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module pipe_ptr_ctr
  import pipe_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Pointer register: clear wins over increment; wraps after the last slot.
  // For power-of-two depths the compare matches natural binary wrap, and it
  // keeps a single-entry buffer pinned at slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule : pipe_ptr_ctr
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : pipe_stage_buf                                             |
// | Purpose  : Elastic valid/ready pipeline register between two core     |
// |            stages: DEPTH-entry FIFO, no fall-through, sync flush.     |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = PIPE_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  // Both ready and valid come from registered occupancy only, so the
  // buffer breaks any combinational path between the two stages.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  // Write and read pointers; a flush snaps both back to slot 0.
  pipe_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (push & ~flush),
    .ptr   (wr_ptr)
  );

  pipe_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (pop & ~flush),
    .ptr   (rd_ptr)
  );

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Occupancy register: reset and flush both empty the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // Payload storage is deliberately not reset; a flushed push is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifndef SYNTHESIS
  localparam bit DEPTH_OK = (DEPTH >= 1) && (DEPTH <= 16) &&
                            ((DEPTH & (DEPTH - 1)) == 0);

  a_depth_pow2: assert property (@(posedge clk) DEPTH_OK);
  a_count_max:  assert property (@(posedge clk) disable iff (!reset) count <= FULL_CNT);
  a_push_ready: assert property (@(posedge clk) disable iff (!reset) push |-> in_ready);
  a_pop_valid:  assert property (@(posedge clk) disable iff (!reset) pop |-> out_valid);
`endif

endmodule : pipe_stage_buf
`default_nettype wire
